// File: rtl/line_bram_writer.sv
// line_bram_writer: producer side of a ping-pong VGA line buffer.
// Accepts an RGB444 pixel stream and writes one pixel per 16-bit BRAM word
// into the bank selected by wr_bank; the bank flips on each line_sync.
// Optional feature macro: LINE_WRITER_UNDERRUN_CNT_EN builds a saturating
// 16-bit underrun counter; without it underrun_cnt is tied to zero.
module line_bram_writer #(
   parameter int LINE_PIXELS     = 640,
   parameter int LINES_PER_FRAME = 480,
   parameter int ADDR_W          = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              line_sync,
   input  logic              frame_sync,
   input  logic [11:0]       s_pix_data,
   input  logic              s_pix_valid,
   output logic              s_pix_ready,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [15:0]       bram_din,
   output logic              wr_bank,
   output logic              line_full,
   output logic              underrun,
   output logic [15:0]       underrun_cnt
);

   localparam int LC_W = $clog2(LINES_PER_FRAME + 1);

   typedef enum logic [1:0] {IDLE, FILL, WAIT} state_t;

   state_t          state;
   logic [9:0]      pix_cnt;
   logic [LC_W-1:0] line_cnt;
   logic [LC_W-1:0] line_nxt;
   logic            accept;
   logic            last_pix;
   logic            frame_done;
   logic            underrun_evt;

   // Saturating increment for the underrun counter.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign s_pix_ready  = (state == FILL);
   assign accept       = s_pix_valid & s_pix_ready;
   assign last_pix     = (pix_cnt == 10'(LINE_PIXELS - 1));
   assign line_nxt     = line_cnt + LC_W'(1);
   assign frame_done   = (line_nxt == LC_W'(LINES_PER_FRAME));
   // A swap is only an underrun if the line was not completed in the same cycle;
   // frame_sync takes precedence and never flags an underrun.
   assign underrun_evt = (state == FILL) & line_sync & ~frame_sync & ~(accept & last_pix);

   // Control FSM plus registered BRAM write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wr_bank   <= 1'b0;
         pix_cnt   <= '0;
         line_cnt  <= '0;
         bram_en   <= 1'b0;
         bram_we   <= 1'b0;
         bram_addr <= '0;
         bram_din  <= '0;
         line_full <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         bram_en   <= 1'b0;
         bram_we   <= 1'b0;
         line_full <= 1'b0;
         // An accepted pixel is always written, even if the same cycle swaps banks.
         if (accept) begin
            bram_en   <= 1'b1;
            bram_we   <= 1'b1;
            bram_addr <= {{(ADDR_W-11){1'b0}}, wr_bank, pix_cnt};
            bram_din  <= {4'h0, s_pix_data};
            line_full <= last_pix;
         end
         if (underrun_evt)
            underrun <= 1'b1;
         if (frame_sync) begin
            state    <= FILL;
            wr_bank  <= 1'b0;
            pix_cnt  <= '0;
            line_cnt <= '0;
         end else begin
            case (state)
               FILL: begin
                  if (line_sync) begin
                     wr_bank  <= ~wr_bank;
                     pix_cnt  <= '0;
                     line_cnt <= line_nxt;
                     state    <= frame_done ? IDLE : FILL;
                  end else if (accept) begin
                     if (last_pix) begin
                        pix_cnt <= '0;
                        state   <= WAIT;
                     end else begin
                        pix_cnt <= pix_cnt + 10'd1;
                     end
                  end
               end
               WAIT: begin
                  if (line_sync) begin
                     wr_bank  <= ~wr_bank;
                     line_cnt <= line_nxt;
                     state    <= frame_done ? IDLE : FILL;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef LINE_WRITER_UNDERRUN_CNT_EN
   logic [15:0] ucnt;

   // Count underrun events, holding at all-ones.
   always_ff @(posedge clk) begin
      if (reset)
         ucnt <= '0;
      else if (underrun_evt)
         ucnt <= sat_inc(ucnt);
   end

   assign underrun_cnt = ucnt;
`else
   assign underrun_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_line_bram_writer.sv
// Directed testbench for line_bram_writer (LINES_PER_FRAME = 4).
module tb_line_bram_writer;

   localparam int LP = 640;
   localparam int LPF = 4;
   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          line_sync = 1'b0;
   logic          frame_sync = 1'b0;
   logic [11:0]   s_pix_data = '0;
   logic          s_pix_valid = 1'b0;
   logic          s_pix_ready;
   logic          bram_en;
   logic          bram_we;
   logic [AW-1:0] bram_addr;
   logic [15:0]   bram_din;
   logic          wr_bank;
   logic          line_full;
   logic          underrun;
   logic [15:0]   underrun_cnt;

   int checks = 0;
   int errors = 0;

`ifdef LINE_WRITER_UNDERRUN_CNT_EN
   localparam logic [15:0] EXP_UCNT = 16'd1;
`else
   localparam logic [15:0] EXP_UCNT = 16'd0;
`endif

   line_bram_writer #(.LINE_PIXELS(LP), .LINES_PER_FRAME(LPF), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .line_sync(line_sync), .frame_sync(frame_sync),
      .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .wr_bank(wr_bank), .line_full(line_full), .underrun(underrun),
      .underrun_cnt(underrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame();
      frame_sync = 1'b1; tick(); frame_sync = 1'b0;
   endtask

   task automatic pulse_line();
      line_sync = 1'b1; tick(); line_sync = 1'b0;
   endtask

   // Stream n pixels (data = index) and check each write the cycle after acceptance.
   task automatic send_line(input string name, input int base, input int n, input bit full);
      int bad = 0;
      logic [15:0] exp_din;
      for (int i = 0; i < n; i++) begin
         s_pix_valid = 1'b1;
         s_pix_data  = 12'(i);
         tick();
         exp_din = {4'h0, 12'(i)};
         if (bram_en !== 1'b1 || bram_we !== 1'b1 || bram_addr !== AW'(base + i) ||
             bram_din !== exp_din || line_full !== (full && i == n - 1)) begin
            if (bad == 0)
               $display("FAIL %s pix %0d: en=%b we=%b addr=%0d din=%h lf=%b, want addr=%0d din=%h lf=%b",
                        name, i, bram_en, bram_we, bram_addr, bram_din, line_full,
                        base + i, exp_din, (full && i == n - 1));
            bad++;
         end
      end
      s_pix_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s: %0d bad writes, want 0", name, bad);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      checks++;
      if ({s_pix_ready, bram_en, bram_we, wr_bank, line_full, underrun} !== 6'b0 ||
          bram_addr !== '0 || bram_din !== 16'h0 || underrun_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_vals: rdy=%b en=%b we=%b bank=%b lf=%b ur=%b addr=%0d din=%h cnt=%0d, want all 0",
                  s_pix_ready, bram_en, bram_we, wr_bank, line_full, underrun, bram_addr, bram_din, underrun_cnt);
      end
      pulse_line();
      checks++;
      if (s_pix_ready !== 1'b0 || wr_bank !== 1'b0) begin
         errors++;
         $display("FAIL idle_line_sync: rdy=%b bank=%b, want 0 0", s_pix_ready, wr_bank);
      end
   endtask

   task automatic test_normal();
      pulse_frame();
      checks++;
      if (s_pix_ready !== 1'b1 || wr_bank !== 1'b0) begin
         errors++;
         $display("FAIL fill_entry: rdy=%b bank=%b, want 1 0", s_pix_ready, wr_bank);
      end
      send_line("normal_line", 0, LP, 1'b1);
      checks++;
      if (s_pix_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_after_full: rdy=%b, want 0", s_pix_ready);
      end
      s_pix_valid = 1'b1;
      tick();
      s_pix_valid = 1'b0;
      checks++;
      if (bram_we !== 1'b0 || line_full !== 1'b0) begin
         errors++;
         $display("FAIL wait_no_write: we=%b lf=%b, want 0 0", bram_we, line_full);
      end
   endtask

   task automatic test_pingpong();
      pulse_line();
      checks++;
      if (wr_bank !== 1'b1 || s_pix_ready !== 1'b1) begin
         errors++;
         $display("FAIL swap1: bank=%b rdy=%b, want 1 1", wr_bank, s_pix_ready);
      end
      send_line("bank1_line", 1024, LP, 1'b1);
      pulse_line();
      checks++;
      if (wr_bank !== 1'b0 || underrun !== 1'b0) begin
         errors++;
         $display("FAIL swap2: bank=%b ur=%b, want 0 0", wr_bank, underrun);
      end
   endtask

   task automatic test_restart();
      pulse_frame();
      send_line("restart_l0", 0, LP, 1'b1);
      pulse_line();
      send_line("restart_part", 1024, 300, 1'b0);
      frame_sync = 1'b1; line_sync = 1'b1;
      tick();
      frame_sync = 1'b0; line_sync = 1'b0;
      checks++;
      if (wr_bank !== 1'b0 || s_pix_ready !== 1'b1 || underrun !== 1'b0) begin
         errors++;
         $display("FAIL restart_prec: bank=%b rdy=%b ur=%b, want 0 1 0", wr_bank, s_pix_ready, underrun);
      end
      send_line("restart_first", 0, 1, 1'b0);
   endtask

   task automatic test_last_with_sync();
      pulse_frame();
      send_line("lws_body", 0, LP - 1, 1'b0);
      s_pix_valid = 1'b1; s_pix_data = 12'(LP - 1); line_sync = 1'b1;
      tick();
      s_pix_valid = 1'b0; line_sync = 1'b0;
      checks++;
      if (bram_we !== 1'b1 || bram_addr !== AW'(LP - 1) || line_full !== 1'b1 ||
          underrun !== 1'b0 || wr_bank !== 1'b1 || s_pix_ready !== 1'b1) begin
         errors++;
         $display("FAIL last_with_sync: we=%b addr=%0d lf=%b ur=%b bank=%b rdy=%b, want 1 %0d 1 0 1 1",
                  bram_we, bram_addr, line_full, underrun, wr_bank, s_pix_ready, LP - 1);
      end
   endtask

   task automatic test_underrun();
      pulse_frame();
      send_line("ur_partial", 0, 100, 1'b0);
      pulse_line();
      checks++;
      if (underrun !== 1'b1 || wr_bank !== 1'b1 || s_pix_ready !== 1'b1 || underrun_cnt !== EXP_UCNT) begin
         errors++;
         $display("FAIL underrun: ur=%b bank=%b rdy=%b cnt=%0d, want 1 1 1 %0d",
                  underrun, wr_bank, s_pix_ready, underrun_cnt, EXP_UCNT);
      end
      send_line("ur_next", 1024, 1, 1'b0);
   endtask

   task automatic test_frame_end();
      int wr = 0;
      pulse_frame();
      for (int l = 0; l < LPF; l++) begin
         send_line("frame_line", (l % 2) * 1024, LP, 1'b1);
         pulse_line();
      end
      checks++;
      if (s_pix_ready !== 1'b0 || wr_bank !== 1'b0) begin
         errors++;
         $display("FAIL frame_end: rdy=%b bank=%b, want 0 0", s_pix_ready, wr_bank);
      end
      s_pix_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bram_we !== 1'b0) wr++;
      end
      s_pix_valid = 1'b0;
      pulse_line();
      pulse_line();
      checks++;
      if (wr != 0 || wr_bank !== 1'b0 || s_pix_ready !== 1'b0 || underrun_cnt !== EXP_UCNT) begin
         errors++;
         $display("FAIL post_frame: writes=%0d bank=%b rdy=%b cnt=%0d, want 0 0 0 %0d",
                  wr, wr_bank, s_pix_ready, underrun_cnt, EXP_UCNT);
      end
   endtask

   task automatic test_backpressure_reset();
      int idx = 0;
      int bad = 0;
      logic v;
      pulse_frame();
      for (int c = 0; c < 200; c++) begin
         v = 1'($urandom_range(0, 1));
         s_pix_valid = v;
         s_pix_data  = 12'(idx + 12'h100);
         tick();
         if (v) begin
            if (bram_we !== 1'b1 || bram_addr !== AW'(idx) || bram_din !== {4'h0, 12'(idx + 12'h100)}) bad++;
            idx++;
         end else if (bram_we !== 1'b0) begin
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL backpressure: %0d bad cycles over %0d pixels, want 0", bad, idx);
      end
      s_pix_valid = 1'b1;
      reset = 1'b1;
      tick();
      checks++;
      if ({s_pix_ready, bram_en, bram_we, wr_bank, line_full, underrun} !== 6'b0 ||
          bram_addr !== '0 || bram_din !== 16'h0 || underrun_cnt !== 16'h0) begin
         errors++;
         $display("FAIL midline_reset: rdy=%b en=%b we=%b bank=%b lf=%b ur=%b addr=%0d din=%h cnt=%0d, want all 0",
                  s_pix_ready, bram_en, bram_we, wr_bank, line_full, underrun, bram_addr, bram_din, underrun_cnt);
      end
      reset = 1'b0;
      s_pix_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal();
      test_pingpong();
      test_restart();
      test_last_with_sync();
      test_underrun();
      test_frame_end();
      test_backpressure_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_bram_writer.md
# line_bram_writer

Producer side of the VGA line buffer. It accepts a 12-bit RGB444 pixel stream and writes it into a ping-pong line BRAM, one pixel per 16-bit word. The bank swaps on every `line_sync` from the scan-out side, so the scan-out logic always reads a complete line while the next line is filled. It runs in the DDR clock domain and consumes the already-synchronised `line_sync_200` / `frame_sync_200` pulses.

## Interface
Parameters:
- `LINE_PIXELS`, 640: pixels per line; must be ≤ 1024.
- `LINES_PER_FRAME`, 480: lines filled per frame.
- `ADDR_W`, 13: BRAM word address width. Bit 10 is the bank select; bits 9:0 are the pixel index.

Ports:
- `clk`  in  1: DDR-domain clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `line_sync`  in  1: single-cycle pulse; the reader has started consuming the bank most recently filled.
- `frame_sync`  in  1: single-cycle pulse; start of a new frame.
- `s_pix_data`  in  12: pixel, {R[3:0], G[3:0], B[3:0]}.
- `s_pix_valid`  in  1: `s_pix_data` is valid.
- `s_pix_ready`  out  1: block accepts a pixel this cycle.
- `bram_en`  out  1: BRAM port enable.
- `bram_we`  out  1: BRAM write enable.
- `bram_addr`  out  ADDR_W: BRAM word address.
- `bram_din`  out  16: BRAM write data, {4'h0, pixel}.
- `wr_bank`  out  1: bank currently being filled.
- `line_full`  out  1: single-cycle pulse when the last pixel of a line is written.
- `underrun`  out  1: sticky flag; a line was incomplete at swap.
- `underrun_cnt`  out  16: saturating count of underruns (see Configuration).

## Operation
State machine with states IDLE, FILL, WAIT. Reset state is IDLE.
- **IDLE:** `s_pix_ready` = 0.
  - `frame_sync` → FILL, with `wr_bank` = 0, pixel count = 0, line count = 0.
- **FILL:** `s_pix_ready` = 1.
  - Each accepted pixel (`s_pix_valid & s_pix_ready`) is written to address {`wr_bank`, pixel_cnt[9:0]}, zero-extended to ADDR_W.
  - pixel_cnt then increments.
  - On accepting pixel `LINE_PIXELS-1`: state → WAIT and pixel_cnt → 0.
- **WAIT:** `s_pix_ready` = 0.
  - `line_sync` → toggle `wr_bank` and increment line count.
  - If the new line count equals `LINES_PER_FRAME`, go to IDLE; otherwise go to FILL.
- **Underrun:** `line_sync` arrives while in FILL.
  - Set `underrun`; increment `underrun_cnt`.
  - Toggle `wr_bank`, clear pixel_cnt, increment line count.
  - Next state follows the same rule as WAIT (IDLE at `LINES_PER_FRAME`, else FILL).
  - Unwritten words of the abandoned bank keep stale data.
- **`line_sync` in IDLE:** ignored.
- **`frame_sync` in any state:** restarts the frame exactly as from IDLE.
  - Any partial line is discarded.
  - `underrun` is not set by this restart.
- **Simultaneous `frame_sync` and `line_sync`:** `frame_sync` wins; `line_sync` is ignored.
- **Simultaneous pixel accept and `line_sync` in FILL:** the pixel is written first, then the swap applies.
  - If that pixel completes the line, this is a normal completion followed by a swap, with no underrun.
- **Clearing `underrun`:** only by `reset`.
- **Line count width:** wide enough for `LINES_PER_FRAME`; it never wraps within a frame.

## Timing
- **Reset values:**
  - State IDLE; `s_pix_ready` 0.
  - `bram_en`, `bram_we` 0; `bram_addr` 0; `bram_din` 0.
  - `wr_bank` 0; `line_full` 0; `underrun` 0; `underrun_cnt` 0.
- **`s_pix_ready`:** decoded combinationally from the registered state; it does not depend on `s_pix_valid`.
- **Write latency:** pixel accepted in cycle t gives `bram_en` = `bram_we` = 1 with the matching `bram_addr` / `bram_din` in cycle t+1.
  - All BRAM outputs are registered.
  - `bram_en` / `bram_we` are 0 whenever no write is issued.
- **Throughput:** one pixel per cycle in FILL.
- **`line_full`:** asserted in cycle t+1, coincident with the BRAM write of the last pixel.
  - `s_pix_ready` is 0 from cycle t+1.
- **Swap:** `line_sync` in cycle t changes `wr_bank` and state in cycle t+1.
  - The first pixel of the new line can be accepted in cycle t+1.

## Configuration
- Macro: `LINE_WRITER_UNDERRUN_CNT_EN`.
- **Defined:** `underrun_cnt` is a 16-bit counter that increments on each underrun and saturates at 16'hFFFF.
- **Undefined:** `underrun_cnt` is tied to 16'h0000 and no counter is built.
- `underrun` behaves identically in both builds.

## Test plan
- **Normal line:** reset, `frame_sync`, 640 pixels with valid held high (data = index).
  - Expect writes at addresses 0..639, `bram_din` = {4'h0, index}.
  - Expect `line_full` on the 640th write; `s_pix_ready` = 0 afterwards.
- **Ping-pong:** after the first line, pulse `line_sync`, send 640 more pixels.
  - Expect writes at 1024..1663 and `wr_bank` = 1.
  - A second `line_sync` returns `wr_bank` to 0.
- **Underrun:** `frame_sync`, 100 pixels, then `line_sync`.
  - Expect `underrun` = 1 and `wr_bank` = 1.
  - Next pixel written at 1024; `underrun_cnt` = 1 with the macro defined, 0 without.
- **Frame end:** with `LINES_PER_FRAME` = 4, fill 4 lines, each followed by `line_sync`.
  - After the 4th `line_sync`: state IDLE, `s_pix_ready` = 0, no further writes.
  - Further `line_sync` pulses are ignored.
- **Frame restart precedence:** mid-line (pixel 300, bank 1), pulse `frame_sync` and `line_sync` together.
  - Expect `wr_bank` = 0 and the next write at address 0.
  - Expect `underrun` unchanged.
- **Backpressure/reset:** toggle `s_pix_valid` randomly and check addresses stay contiguous.
  - Assert `reset` mid-line: all outputs return to reset values the next cycle.
